divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 131 +++++++++++++
 tb/tb_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential 32-bit signed divider with MIPS DIV semantics.
// One restoring step per clock on unsigned magnitudes; signs are fixed up when the result is loaded.
module divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] high,
    output logic [31:0] low,
    output logic        div_end,
    output logic        div_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [5:0]  r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_absB;
    logic        r_negQuo;
    logic        r_negRem;

    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic        w_start;
    logic        w_zero;
    logic        w_lastStep;
    logic [32:0] w_shifted;
    logic [32:0] w_diff;
    logic        w_fits;

    // Magnitudes; the most negative value maps onto 0x80000000 as an unsigned number.
    assign w_absA     = a[31] ? (~a + 32'd1) : a;
    assign w_absB     = b[31] ? (~b + 32'd1) : b;

    assign w_start    = (r_state == IDLE) && div && (b != 32'd0);
    assign w_zero     = (r_state == IDLE) && div && (b == 32'd0);
    assign w_lastStep = (r_count == 6'd31);

    // The dividend sits in r_quo and shifts into the remainder one bit per step.
    assign w_shifted  = {r_rem, r_quo[31]};
    assign w_diff     = w_shifted - {1'b0, r_absB};
    assign w_fits     = (w_shifted >= {1'b0, r_absB});

    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 6'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_absB   <= 32'd0;
            r_negQuo <= 1'b0;
            r_negRem <= 1'b0;
            high     <= 32'd0;
            low      <= 32'd0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            div_end  <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_quo    <= w_absA;
                        r_absB   <= w_absB;
                        r_rem    <= 32'd0;
                        r_count  <= 6'd0;
                        r_negRem <= a[31];
                        r_negQuo <= a[31] ^ b[31];
                    end else if (w_zero) begin
                        div_zero <= 1'b1;
                    end
                end
                CALC: begin
                    r_rem   <= w_fits ? w_diff[31:0] : w_shifted[31:0];
                    r_quo   <= {r_quo[30:0], w_fits};
                    r_count <= r_count + 6'd1;
                end
                DONE: begin
                    low     <= r_negQuo ? (~r_quo + 32'd1) : r_quo;
                    high    <= r_negRem ? (~r_rem + 32'd1) : r_rem;
                    div_end <= 1'b1;
                end
                default: begin
                    r_count <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for the divider against a plain-arithmetic model.
module tb_divider;

    logic        clk;
    logic        reset;
    logic        div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] high;
    logic [31:0] low;
    logic        div_end;
    logic        div_zero;
    logic        busy;

    int          checks;
    int          errors;
    logic [31:0] expHigh;
    logic [31:0] expLow;

    divider dut (
        .clk      (clk),
        .reset    (reset),
        .div      (div),
        .a        (a),
        .b        (b),
        .high     (high),
        .low      (low),
        .div_end  (div_end),
        .div_zero (div_zero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference: 64-bit signed division truncates toward zero and the remainder keeps the
    // dividend's sign; truncating to 32 bits gives the wrapped result for 0x80000000 / -1.
    task automatic modelDiv(input logic [31:0] ta, input logic [31:0] tb, output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint qv;
        longint rv;
        sa = longint'($signed(ta));
        sb = longint'($signed(tb));
        qv = sa / sb;
        rv = sa % sb;
        q  = 32'(qv);
        r  = 32'(rv);
    endtask

    // Launch one division (releasing reset at the same time), disturb the inputs while it runs,
    // then check latency, pulse shape and result.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input bit scramble, input string tag);
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
        bit          zeroSeen;
        @(negedge clk);
        reset = 1'b0;
        a     = ta;
        b     = tb;
        div   = 1'b1;
        modelDiv(ta, tb, q, r);
        @(posedge clk);
        #1;
        checkOutput({tag, "_busy_start"}, 32'(busy), 32'd1);
        checkOutput({tag, "_end_start"}, 32'(div_end), 32'd0);
        cyc      = 0;
        zeroSeen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            div = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
            a   = $urandom;
            b   = $urandom;
            if (scramble && k == 5) begin
                a   = 32'd50;
                b   = 32'd5;
                div = 1'b1;
            end
            @(posedge clk);
            #1;
            if (div_zero) zeroSeen = 1'b1;
            if (div_end) begin
                cyc = k;
                break;
            end
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd33);
        checkOutput({tag, "_low"}, low, q);
        checkOutput({tag, "_high"}, high, r);
        checkOutput({tag, "_nozero"}, 32'(zeroSeen), 32'd0);
        checkOutput({tag, "_busy_end"}, 32'(busy), 32'd0);
        expLow  = q;
        expHigh = r;
    endtask

    task automatic applyZero(input logic [31:0] ta, input string tag);
        bit endSeen;
        @(negedge clk);
        a   = ta;
        b   = 32'd0;
        div = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_zero_pulse"}, 32'(div_zero), 32'd1);
        checkOutput({tag, "_zero_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_zero_low"}, low, expLow);
        checkOutput({tag, "_zero_high"}, high, expHigh);
        @(negedge clk);
        div = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_zero_clear"}, 32'(div_zero), 32'd0);
        endSeen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (div_end || busy) endSeen = 1'b1;
        end
        checkOutput({tag, "_zero_noend"}, 32'(endSeen), 32'd0);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_high"}, high, 32'd0);
        checkOutput({tag, "_low"}, low, 32'd0);
        checkOutput({tag, "_end"}, 32'(div_end), 32'd0);
        checkOutput({tag, "_zero"}, 32'(div_zero), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        bit          endSeen;
        checks  = 0;
        errors  = 0;
        expHigh = 32'd0;
        expLow  = 32'd0;
        reset   = 1'b1;
        div     = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        repeat (3) @(negedge clk);
        checkCleared("reset");

        applyStimulus(32'd7, 32'd2, 1'b0, "pos7by2");
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, "neg7by2");
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b0, "pos7byneg2");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "minbyneg1");
        applyZero(32'd100, "div100by0");
        applyStimulus(32'd7, 32'd2, 1'b1, "repulse");

        // Abort a division with an asynchronous reset between clock edges.
        @(negedge clk);
        a   = 32'd7;
        b   = 32'd2;
        div = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkCleared("abort");
        expHigh = 32'd0;
        expLow  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        endSeen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_end) endSeen = 1'b1;
        end
        checkOutput("abort_noend", 32'(endSeen), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        applyStimulus(32'd9, 32'd4, 1'b0, "afterreset");

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 7);
            ra  = (sel == 4) ? 32'h8000_0000 : $urandom;
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 20);
                3: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if (rb == 32'd0) applyZero(ra, "rand");
            else applyStimulus(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
